// File: rtl/touch_filter.sv
// Touchscreen sample conditioner: averages bursts of 2^AVG_LOG2 pen-down samples,
// rejects bursts whose per-axis spread is too large, and paces coordinate output.
module touch_filter #(
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned MAX_SPREAD = 64,
    parameter int unsigned HOLDOFF    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        pen_down,
    input  logic        sample_valid,
    input  logic [11:0] x_raw,
    input  logic [11:0] y_raw,
    output logic        pos_ready,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [7:0]  reject_count
);

    localparam int unsigned SW     = 12 + AVG_LOG2;
    localparam int unsigned CW     = AVG_LOG2 + 1;
    localparam int unsigned HW     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int unsigned NBURST = 1 << AVG_LOG2;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_CHECK, S_EMIT, S_HOLD} state_t;

    state_t         r_state;
    logic [SW-1:0]  r_sum_x;
    logic [SW-1:0]  r_sum_y;
    logic [11:0]    r_min_x;
    logic [11:0]    r_max_x;
    logic [11:0]    r_min_y;
    logic [11:0]    r_max_y;
    logic [CW-1:0]  r_cnt;
    logic [HW-1:0]  r_hold;
    logic [11:0]    r_x_pos;
    logic [11:0]    r_y_pos;
    logic [7:0]     r_reject;

    logic           w_first;
    logic           w_last;
    logic           w_accept;
    logic [11:0]    w_spread_x;
    logic [11:0]    w_spread_y;
    logic [11:0]    w_min_x;
    logic [11:0]    w_max_x;
    logic [11:0]    w_min_y;
    logic [11:0]    w_max_y;

    // The first sample of a burst seeds both trackers.
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == CW'(NBURST - 1));
    assign w_min_x    = (w_first || x_raw < r_min_x) ? x_raw : r_min_x;
    assign w_max_x    = (w_first || x_raw > r_max_x) ? x_raw : r_max_x;
    assign w_min_y    = (w_first || y_raw < r_min_y) ? y_raw : r_min_y;
    assign w_max_y    = (w_first || y_raw > r_max_y) ? y_raw : r_max_y;
    assign w_spread_x = r_max_x - r_min_x;
    assign w_spread_y = r_max_y - r_min_y;
    assign w_accept   = ({1'b0, w_spread_x} <= 13'(MAX_SPREAD)) &&
                        ({1'b0, w_spread_y} <= 13'(MAX_SPREAD));

    assign pos_ready    = (r_state == S_EMIT);
    assign x_pos        = r_x_pos;
    assign y_pos        = r_y_pos;
    assign reject_count = r_reject;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sum_x  <= '0;
            r_sum_y  <= '0;
            r_min_x  <= '0;
            r_max_x  <= '0;
            r_min_y  <= '0;
            r_max_y  <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_x_pos  <= '0;
            r_y_pos  <= '0;
            r_reject <= '0;
        end else if (en) begin
            // Outside ACCUM the burst is always empty; CHECK reads the old values before they clear.
            if (r_state != S_ACCUM) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_min_x <= '0;
                r_max_x <= '0;
                r_min_y <= '0;
                r_max_y <= '0;
                r_cnt   <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (pen_down) r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (!pen_down) begin
                        r_sum_x <= '0;
                        r_sum_y <= '0;
                        r_min_x <= '0;
                        r_max_x <= '0;
                        r_min_y <= '0;
                        r_max_y <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (sample_valid) begin
                        r_sum_x <= r_sum_x + SW'(x_raw);
                        r_sum_y <= r_sum_y + SW'(y_raw);
                        r_min_x <= w_min_x;
                        r_max_x <= w_max_x;
                        r_min_y <= w_min_y;
                        r_max_y <= w_max_y;
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_last) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_x_pos <= 12'(r_sum_x >> AVG_LOG2);
                        r_y_pos <= 12'(r_sum_y >> AVG_LOG2);
                        r_state <= S_EMIT;
                    end else begin
                        if (r_reject != 8'hFF) r_reject <= r_reject + 8'd1;
                        r_state <= pen_down ? S_ACCUM : S_IDLE;
                    end
                end
                S_EMIT: begin
                    r_hold  <= '0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold == HW'(HOLDOFF - 1)) begin
                        r_state <= pen_down ? S_ACCUM : S_IDLE;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_filter.sv
// Bench for touch_filter: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a queue-based burst model.
module tb_touch_filter;

    localparam int unsigned AVG_LOG2   = 2;
    localparam int unsigned N          = 4;
    localparam int unsigned MAX_SPREAD = 64;
    localparam int unsigned HOLDOFF    = 3;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_CHECK   = 2;
    localparam int P_EMIT    = 3;
    localparam int P_HOLD    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        pen_down;
    logic        sample_valid;
    logic [11:0] x_raw;
    logic [11:0] y_raw;
    logic        pos_ready;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [7:0]  reject_count;

    always #5 clk = ~clk;

    touch_filter #(
        .AVG_LOG2  (AVG_LOG2),
        .MAX_SPREAD(MAX_SPREAD),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pen_down    (pen_down),
        .sample_valid(sample_valid),
        .x_raw       (x_raw),
        .y_raw       (y_raw),
        .pos_ready   (pos_ready),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .reject_count(reject_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit cmp_on   = 1'b0;
    bit prev_ready = 1'b0;
    int n_pulse  = 0;
    int pulses[$];

    // Model: burst contents held as queues; outputs derived from arithmetic on them.
    int m_phase = P_IDLE;
    int m_hold  = 0;
    int m_x     = 0;
    int m_y     = 0;
    int m_rej   = 0;
    int qx[$];
    int qy[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int spread(input int q[$]);
        int lo = q[0];
        int hi = q[0];
        foreach (q[i]) begin
            if (q[i] < lo) lo = q[i];
            if (q[i] > hi) hi = q[i];
        end
        return hi - lo;
    endfunction

    function automatic int total(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_phase = P_IDLE;
            qx.delete();
            qy.delete();
            m_x = 0;
            m_y = 0;
            m_rej = 0;
        end else if (en) begin
            case (m_phase)
                P_IDLE: begin
                    qx.delete();
                    qy.delete();
                    if (pen_down) m_phase = P_COLLECT;
                end
                P_COLLECT: begin
                    if (!pen_down) begin
                        qx.delete();
                        qy.delete();
                        m_phase = P_IDLE;
                    end else if (sample_valid) begin
                        qx.push_back(int'(x_raw));
                        qy.push_back(int'(y_raw));
                        if (qx.size() == N) m_phase = P_CHECK;
                    end
                end
                P_CHECK: begin
                    if (spread(qx) <= int'(MAX_SPREAD) && spread(qy) <= int'(MAX_SPREAD)) begin
                        m_x = total(qx) / N;
                        m_y = total(qy) / N;
                        m_phase = P_EMIT;
                    end else begin
                        if (m_rej < 255) m_rej++;
                        m_phase = pen_down ? P_COLLECT : P_IDLE;
                    end
                    qx.delete();
                    qy.delete();
                end
                P_EMIT: begin
                    m_hold = HOLDOFF;
                    m_phase = P_HOLD;
                end
                default: begin
                    m_hold--;
                    if (m_hold == 0) m_phase = pen_down ? P_COLLECT : P_IDLE;
                end
            endcase
        end
    endtask

    task automatic compare_step();
        cyc++;
        if (cmp_on) begin
            chk("pos_ready", int'(pos_ready), int'(m_phase == P_EMIT));
            chk("x_pos", int'(x_pos), m_x);
            chk("y_pos", int'(y_pos), m_y);
            chk("reject_count", int'(reject_count), m_rej);
        end
        if (pos_ready && !prev_ready) begin
            n_pulse++;
            pulses.push_back(cyc);
        end
        prev_ready = pos_ready;
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) compare_step();

    task automatic drive(input logic pen, input logic sv, input int x, input int y);
        pen_down     = pen;
        sample_valid = sv;
        x_raw        = 12'(x);
        y_raw        = 12'(y);
        @(negedge clk);
    endtask

    task automatic pen_up(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic burst(input int xs[4], input int ys[4]);
        drive(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, xs[i], ys[i]);
        pen_up(8);
    endtask

    initial begin
        int xs[4];
        int ys[4];
        int p0;
        int bx;
        reset = 1'b1;
        en = 1'b1;
        pen_down = 1'b0;
        sample_valid = 1'b0;
        x_raw = '0;
        y_raw = '0;
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        cmp_on = 1'b1;
        chk("rst_ready", int'(pos_ready), 0);
        chk("rst_x", int'(x_pos), 0);
        chk("rst_y", int'(y_pos), 0);
        chk("rst_rej", int'(reject_count), 0);

        // Constant burst: pulse two cycles after the last sample
        p0 = n_pulse;
        drive(1'b1, 1'b0, 0, 0);
        repeat (4) drive(1'b1, 1'b1, 1000, 2500);
        chk("t1_check_cycle_ready", int'(pos_ready), 0);
        drive(1'b0, 1'b0, 0, 0);
        chk("t1_ready", int'(pos_ready), 1);
        chk("t1_x", int'(x_pos), 1000);
        chk("t1_y", int'(y_pos), 2500);
        pen_up(8);
        chk("t1_pulses", n_pulse - p0, 1);

        // Floor average
        p0 = n_pulse;
        xs = '{1, 2, 3, 4};
        ys = '{3000, 3000, 3000, 3000};
        burst(xs, ys);
        chk("t2_pulses", n_pulse - p0, 1);
        chk("t2_x", int'(x_pos), 2);
        chk("t2_y", int'(y_pos), 3000);
        chk("t2_rej", int'(reject_count), 0);

        // Spread 100 rejected
        p0 = n_pulse;
        xs = '{1000, 1000, 1000, 1100};
        ys = '{500, 500, 500, 500};
        burst(xs, ys);
        chk("t3_pulses", n_pulse - p0, 0);
        chk("t3_rej", int'(reject_count), 1);
        chk("t3_x_held", int'(x_pos), 2);

        // Pen lift mid-burst discards partial samples
        p0 = n_pulse;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 5, 5);
        drive(1'b1, 1'b1, 5, 5);
        drive(1'b0, 1'b1, 7, 7);
        drive(1'b1, 1'b1, 9, 9);
        repeat (4) drive(1'b1, 1'b1, 600, 2048);
        pen_up(8);
        chk("t4_pulses", n_pulse - p0, 1);
        chk("t4_x", int'(x_pos), 600);
        chk("t4_y", int'(y_pos), 2048);

        // Continuous samples: pulse spacing
        p0 = pulses.size();
        repeat (40) drive(1'b1, 1'b1, 100, 200);
        chk("t5_pulses", pulses.size() - p0, 4);
        for (int i = p0 + 1; i < pulses.size(); i++)
            chk("t5_spacing", pulses[i] - pulses[i-1], 9);

        // en=0 while in EMIT keeps pos_ready high
        for (int i = 0; i < 30 && !pos_ready; i++) drive(1'b1, 1'b1, 100, 200);
        chk("t5_found_emit", int'(pos_ready), 1);
        en = 1'b0;
        repeat (5) begin
            drive(1'b1, 1'b1, 100, 200);
            chk("t5_en0_ready", int'(pos_ready), 1);
        end
        en = 1'b1;
        drive(1'b1, 1'b1, 100, 200);
        chk("t5_fall", int'(pos_ready), 0);
        pen_up(12);

        // Saturating reject counter
        for (int i = 0; i < 1600; i++) drive(1'b1, 1'b1, (i % 2 == 1) ? 4000 : 0, 100);
        chk("t6_rej_sat", int'(reject_count), 255);
        chk("t6_x_held", int'(x_pos), 100);

        // Reset mid-ACCUM, then a clean burst
        drive(1'b1, 1'b1, 50, 50);
        reset = 1'b1;
        drive(1'b1, 1'b1, 50, 50);
        reset = 1'b0;
        chk("t7_ready", int'(pos_ready), 0);
        chk("t7_x", int'(x_pos), 0);
        chk("t7_y", int'(y_pos), 0);
        chk("t7_rej", int'(reject_count), 0);
        pen_up(2);
        xs = '{1234, 1235, 1236, 1237};
        ys = '{7, 8, 9, 10};
        burst(xs, ys);
        chk("t7_avg_x", int'(x_pos), 1235);
        chk("t7_avg_y", int'(y_pos), 8);

        // Random traffic against the model
        bx = 2000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bx = $urandom_range(0, 3800);
            en    = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 29) != 0, $urandom_range(0, 2) != 0,
                  bx + (($urandom_range(0, 9) == 0) ? $urandom_range(0, 250) : $urandom_range(0, 40)),
                  bx + $urandom_range(0, 60));
        end
        reset = 1'b0;
        en = 1'b1;
        pen_up(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
